// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_pkg
// Description : Shared constants and helpers for the multi-channel
//               quarter-wave NCO (pipeline depth, quadrant codes, clog2,
//               sign/mirror sample select).
// Revision    : 1.0 - initial release
// ============================================================================
package nco_pkg;

  // Enabled clock edges from slot issue to the registered output sample
  localparam int LAT = 4;

  // Quadrant codes taken from the top two phase bits
  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // Ceiling log2, used to size the channel index
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < value) w = w + 1;
    end
    return w;
  endfunction

  // Turns a quarter-wave table value into a full-wave sample: the exact
  // peak replaces the table at the quadrant seams, then an optional
  // two's-complement negation applies the quadrant sign.
  function automatic int sample_sel(input int rom_val, input int max_val,
                                    input logic use_max, input logic neg);
    int mag;
    mag = use_max ? max_val : rom_val;
    return neg ? -mag : mag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nco_qwave_rom.sv
`default_nettype none
// ============================================================================
// Module      : nco_qwave_rom
// Description : Dual-read quarter-wave sine table, one registered read
//               stage per port, gated by the global clock enable.
//               Entry k holds round(MAX*sin(pi/2*k/N)), N = 2^RAW; the
//               table is built at elaboration to the same content as the
//               ROM_FILE image so no external file is needed.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_qwave_rom #(
  parameter int RAW      = 10,
  parameter int MPR      = 12,
  parameter     ROM_FILE = "nco_qwave.hex"
) (
  input  logic           clk,
  input  logic           clken,
  input  logic [RAW-1:0] addr_a,
  input  logic [RAW-1:0] addr_b,
  output logic [MPR-2:0] data_a,
  output logic [MPR-2:0] data_b
);

  localparam int  c_n   = 1 << RAW;
  localparam int  c_max = (1 << (MPR - 1)) - 1;
  localparam real c_pi  = 3.14159265358979323846;

  function automatic logic [MPR-2:0] qval(input int k);
    real x;
    x = real'(c_max) * $sin(c_pi / 2.0 * real'(k) / real'(c_n));
    return (MPR-1)'($rtoi(x + 0.5));
  endfunction

  logic [MPR-2:0] w_tab [c_n];

  for (genvar k = 0; k < c_n; k++) begin : g_tab
    assign w_tab[k] = qval(k);
  end

  // Registered read on both ports; holds while the datapath is frozen
  always_ff @(posedge clk) begin
    if (clken) begin
      data_a <= w_tab[addr_a];
      data_b <= w_tab[addr_b];
    end
  end

endmodule
`default_nettype wire

// File: rtl/nco_mc_qwave.sv
`default_nettype none
// ============================================================================
// Module      : nco_mc_qwave
// Description : Time-multiplexed NCH-channel NCO. Channels are issued
//               round-robin, one slot per enabled cycle, through a shared
//               phase adder, quadrant decode, dual-port quarter-wave ROM and
//               sign/mirror output stage. Per-channel increment and offset,
//               global phase sync.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_mc_qwave
  import nco_pkg::*;
#(
  parameter int   NCH      = 4,
  parameter int   APR      = 32,
  parameter int   RAW      = 10,
  parameter int   MPR      = 12,
  parameter       ROM_FILE = "nco_qwave.hex",
  localparam int  CHW      = clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  cfg_wr,
  input  logic [CHW-1:0]        cfg_ch,
  input  logic                  cfg_sel,
  input  logic [APR-1:0]        cfg_data,
  input  logic                  sync_i,
  output logic signed [MPR-1:0] fsin_o,
  output logic signed [MPR-1:0] fcos_o,
  output logic [CHW-1:0]        out_ch,
  output logic                  out_valid
);

  localparam int c_max = (1 << (MPR - 1)) - 1;

  logic [APR-1:0] r_inc [NCH];
  logic [APR-1:0] r_off [NCH];
  logic [APR-1:0] r_acc [NCH];
  logic [CHW-1:0] r_ch_cnt;
  logic [LAT-1:0] r_vld;

  logic [APR-1:0] w_ph;
  logic [RAW+1:0] r_s1_ph;
  logic [CHW-1:0] r_s1_ch;

  logic [1:0]     w_q;
  logic [RAW-1:0] w_a;
  logic [RAW-1:0] w_a_neg;
  logic           w_a_zero;

  logic [RAW-1:0] r_s2_addr_s, r_s2_addr_c;
  logic           r_s2_max_s, r_s2_max_c, r_s2_neg_s, r_s2_neg_c;
  logic [CHW-1:0] r_s2_ch;

  logic [MPR-2:0] w_rom_s, w_rom_c;
  logic           r_s3_max_s, r_s3_max_c, r_s3_neg_s, r_s3_neg_c;
  logic [CHW-1:0] r_s3_ch;

  // Configuration file: writes land regardless of clken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inc <= '{default: '0};
      r_off <= '{default: '0};
    end else if (cfg_wr) begin
      if (cfg_sel) r_off[cfg_ch] <= cfg_data;
      else         r_inc[cfg_ch] <= cfg_data;
    end
  end

  // Slot counter and accumulators; sync zeroes everything ahead of the step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '{default: '0};
      r_ch_cnt <= '0;
    end else if (clken) begin
      if (sync_i) begin
        r_acc    <= '{default: '0};
        r_ch_cnt <= '0;
      end else begin
        r_acc[r_ch_cnt] <= r_acc[r_ch_cnt] + r_inc[r_ch_cnt];
        r_ch_cnt        <= r_ch_cnt + 1'b1;
      end
    end
  end

  // Issued phase uses the accumulator value before this slot's update
  assign w_ph = r_acc[r_ch_cnt] + r_off[r_ch_cnt];

  // Stage valids shift on enabled edges; the output valid drops on a frozen cycle
  always_ff @(posedge clk) begin
    if (reset)      r_vld <= '0;
    else if (clken) r_vld <= {r_vld[LAT-2:0], 1'b1};
    else            r_vld[LAT-1] <= 1'b0;
  end

  assign out_valid = r_vld[LAT-1];

  // S1: capture quadrant plus table-address bits of the phase (rest truncated)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_ph <= '0;
      r_s1_ch <= '0;
    end else if (clken) begin
      r_s1_ph <= (RAW+2)'(w_ph >> (APR - RAW - 2));
      r_s1_ch <= r_ch_cnt;
    end
  end

  assign w_q      = r_s1_ph[RAW+1:RAW];
  assign w_a      = r_s1_ph[RAW-1:0];
  assign w_a_neg  = -w_a;
  assign w_a_zero = (w_a == '0);

  // S2: mirror address and seam/sign flags; cosine is sine one quadrant ahead
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_addr_s <= '0;
      r_s2_addr_c <= '0;
      r_s2_max_s  <= 1'b0;
      r_s2_max_c  <= 1'b0;
      r_s2_neg_s  <= 1'b0;
      r_s2_neg_c  <= 1'b0;
      r_s2_ch     <= '0;
    end else if (clken) begin
      r_s2_addr_s <= (w_q == QUAD_1 || w_q == QUAD_3) ? w_a_neg : w_a;
      r_s2_addr_c <= (w_q == QUAD_0 || w_q == QUAD_2) ? w_a_neg : w_a;
      r_s2_max_s  <= (w_q == QUAD_1 || w_q == QUAD_3) && w_a_zero;
      r_s2_max_c  <= (w_q == QUAD_0 || w_q == QUAD_2) && w_a_zero;
      r_s2_neg_s  <= (w_q == QUAD_2 || w_q == QUAD_3);
      r_s2_neg_c  <= (w_q == QUAD_1 || w_q == QUAD_2);
      r_s2_ch     <= r_s1_ch;
    end
  end

  nco_qwave_rom #(
    .RAW      (RAW),
    .MPR      (MPR),
    .ROM_FILE (ROM_FILE)
  ) u_rom (
    .clk    (clk),
    .clken  (clken),
    .addr_a (r_s2_addr_s),
    .addr_b (r_s2_addr_c),
    .data_a (w_rom_s),
    .data_b (w_rom_c)
  );

  // S3: carry flags alongside the registered ROM read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s3_max_s <= 1'b0;
      r_s3_max_c <= 1'b0;
      r_s3_neg_s <= 1'b0;
      r_s3_neg_c <= 1'b0;
      r_s3_ch    <= '0;
    end else if (clken) begin
      r_s3_max_s <= r_s2_max_s;
      r_s3_max_c <= r_s2_max_c;
      r_s3_neg_s <= r_s2_neg_s;
      r_s3_neg_c <= r_s2_neg_c;
      r_s3_ch    <= r_s2_ch;
    end
  end

  // S4: sign/mirror select into the output registers, only for live samples
  always_ff @(posedge clk) begin
    if (reset) begin
      fsin_o <= '0;
      fcos_o <= '0;
      out_ch <= '0;
    end else if (clken && r_vld[LAT-2]) begin
      fsin_o <= MPR'(sample_sel(int'(w_rom_s), c_max, r_s3_max_s, r_s3_neg_s));
      fcos_o <= MPR'(sample_sel(int'(w_rom_c), c_max, r_s3_max_c, r_s3_neg_c));
      out_ch <= r_s3_ch;
    end
  end

endmodule
`default_nettype wire
